mul_div_unit: RTL and testbench

MUL_DIV_UNIT -- requirements
Module: mul_div_unit

---
 rtl/mul_div_unit.sv | 155 +++++++++++++++
 tb/tb_mul_div_unit.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/mul_div_unit.sv
// Iterative RV32M multiply/divide unit: one shift-add or restoring-division bit per cycle.
// Divide-by-zero and signed-overflow cases skip the iteration and complete in one cycle.
//
// state | meaning
// IDLE  | waiting for start; captures operands and tag
// CALC  | 32 iteration cycles, one product/quotient bit each
// FIX   | sign correction and result selection
// DONE  | done pulse; result and rd_out valid
module mul_div_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] rs1_val,
    input  logic [XLEN-1:0] rs2_val,
    input  logic [4:0]      rd_in,
    input  logic            flush,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic [4:0]      rd_out
);

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    state_t            state, state_nxt;
    logic [4:0]        cnt;
    logic [2:0]        op_q;
    logic [4:0]        rd_q;
    logic              neg_q;
    logic [XLEN-1:0]   opnd_q;
    logic [2*XLEN-1:0] acc;

    logic              is_div, a_signed, b_signed, a_neg, b_neg;
    logic [XLEN-1:0]   a_mag, b_mag;
    logic              div_zero, div_ovf, bypass, accept;
    logic [XLEN-1:0]   bypass_res;

    always_comb begin
        is_div   = funct3[2];
        a_signed = is_div ? ~funct3[0] : (funct3[1:0] != 2'b11);
        b_signed = is_div ? ~funct3[0] : ~funct3[1];
        a_neg    = a_signed & rs1_val[XLEN-1];
        b_neg    = b_signed & rs2_val[XLEN-1];
        a_mag    = a_neg ? -rs1_val : rs1_val;
        b_mag    = b_neg ? -rs2_val : rs2_val;
        div_zero = is_div && (rs2_val == '0);
        div_ovf  = is_div && !funct3[0] && (rs1_val == MIN_NEG) && (rs2_val == '1);
        bypass   = div_zero | div_ovf;
        if (div_zero) begin
            bypass_res = funct3[1] ? rs1_val : '1;
        end else begin
            bypass_res = funct3[1] ? '0 : MIN_NEG;
        end
        accept = (state == IDLE) && start && !flush;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (start) state_nxt = bypass ? DONE : CALC;
            CALC: if (cnt == 5'd31) state_nxt = FIX;
            FIX:  state_nxt = DONE;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (flush) state_nxt = IDLE;
    end

    assign busy = (state == CALC) || (state == FIX);
    assign done = (state == DONE);

    // Multiply: add multiplicand into the high half when the low bit is set, then shift right.
    logic [XLEN:0]     mul_sum;
    logic [2*XLEN-1:0] mul_nxt;
    // Divide: shift dividend bit into the remainder, keep the difference if it did not borrow.
    logic [XLEN:0]     rem_sh, rem_diff;
    logic [2*XLEN-1:0] div_nxt;

    always_comb begin
        mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opnd_q} : '0);
        mul_nxt  = {mul_sum, acc[XLEN-1:1]};
        rem_sh   = acc[2*XLEN-1:XLEN-1];
        rem_diff = rem_sh - {1'b0, opnd_q};
        if (rem_diff[XLEN]) begin
            div_nxt = {rem_sh[XLEN-1:0], acc[XLEN-2:0], 1'b0};
        end else begin
            div_nxt = {rem_diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
        end
    end

    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   div_sel, fix_res;

    always_comb begin
        prod    = neg_q ? -acc : acc;
        div_sel = op_q[1] ? acc[2*XLEN-1:XLEN] : acc[XLEN-1:0];
        if (op_q[2]) begin
            fix_res = neg_q ? -div_sel : div_sel;
        end else if (op_q[1:0] == 2'b00) begin
            fix_res = prod[XLEN-1:0];
        end else begin
            fix_res = prod[2*XLEN-1:XLEN];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt    <= '0;
            op_q   <= '0;
            rd_q   <= '0;
            neg_q  <= 1'b0;
            opnd_q <= '0;
            acc    <= '0;
            result <= '0;
            rd_out <= '0;
        end else if (accept) begin
            cnt   <= '0;
            op_q  <= funct3;
            rd_q  <= rd_in;
            // Remainder takes the dividend's sign; product and quotient take the XOR.
            neg_q <= (funct3[2:1] == 2'b11) ? a_neg : (a_neg ^ b_neg);
            if (is_div) begin
                opnd_q <= b_mag;
                acc    <= {{XLEN{1'b0}}, a_mag};
            end else begin
                opnd_q <= a_mag;
                acc    <= {{XLEN{1'b0}}, b_mag};
            end
            if (bypass) begin
                result <= bypass_res;
                rd_out <= rd_in;
            end
        end else if (state == CALC) begin
            cnt <= cnt + 5'd1;
            acc <= op_q[2] ? div_nxt : mul_nxt;
        end else if (state == FIX && !flush) begin
            result <= fix_res;
            rd_out <= rd_q;
        end
    end

endmodule

// File: tb/tb_mul_div_unit.sv
// Bench for mul_div_unit: directed vector table, flush/reset sequences and
// randomized operations against a plain-arithmetic reference model.
module tb_mul_div_unit;

    logic        clk = 1'b0;
    logic        rst, start, flush;
    logic [2:0]  funct3;
    logic [31:0] rs1_val, rs2_val;
    logic [4:0]  rd_in;
    logic        busy, done;
    logic [31:0] result;
    logic [4:0]  rd_out;

    int checks = 0;
    int errors = 0;

    mul_div_unit #(.XLEN(32)) dut (
        .clk(clk), .rst(rst), .start(start), .funct3(funct3),
        .rs1_val(rs1_val), .rs2_val(rs2_val), .rd_in(rd_in), .flush(flush),
        .busy(busy), .done(done), .result(result), .rd_out(rd_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] ref_model(input logic [2:0] f3, input logic [31:0] a,
                                             input logic [31:0] b);
        logic [63:0] ax, bx, p;
        int          sa, sb, sq;
        logic        ovf;
        sa  = $signed(a);
        sb  = $signed(b);
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        ax  = (f3 != 3'b011) ? {{32{a[31]}}, a} : {32'h0, a};
        bx  = (f3 == 3'b000 || f3 == 3'b001) ? {{32{b[31]}}, b} : {32'h0, b};
        p   = ax * bx;
        case (f3)
            3'b000:  return p[31:0];
            3'b100: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (ovf) return 32'h8000_0000;
                sq = sa / sb;
                return sq;
            end
            3'b101:  return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'b110: begin
                if (b == 0) return a;
                if (ovf) return 32'h0;
                sq = sa % sb;
                return sq;
            end
            3'b111:  return (b == 0) ? a : a % b;
            default: return p[63:32];
        endcase
    endfunction

    // Issues one op (start high during cycle N) and observes cycles N+1..N+ncyc.
    task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd, input int ncyc, input bit stop_early,
                          output logic [31:0] res, output logic [4:0] rdo,
                          output int lat, output int ndone, output int nbusy);
        @(negedge clk);
        start = 1'b1; funct3 = f3; rs1_val = a; rs2_val = b; rd_in = rd;
        lat = 0; ndone = 0; nbusy = 0; res = '0; rdo = '0;
        for (int c = 1; c <= ncyc; c++) begin
            @(posedge clk); #1;
            if (c == 1) start = 1'b0;
            if (busy) nbusy++;
            if (done) begin
                ndone++;
                if (lat == 0) begin
                    lat = c; res = result; rdo = rd_out;
                end
            end
            if (stop_early && lat != 0 && c > lat) break;
        end
    endtask

    typedef struct {
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        logic [31:0] exp_res;
        int          exp_lat;
    } vec_t;

    vec_t vecs[9];

    initial begin
        logic [31:0] res, a, b;
        logic [4:0]  rdo, rd;
        logic [2:0]  f3;
        int          lat, ndone, nbusy, exp_lat;
        logic [31:0] corners[6];
        string       nm;

        vecs[0] = '{3'b000, 32'h0000_0007, 32'hFFFF_FFFD, 5'd1,  32'hFFFF_FFEB, 34};
        vecs[1] = '{3'b001, 32'h8000_0000, 32'h8000_0000, 5'd2,  32'h4000_0000, 34};
        vecs[2] = '{3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3,  32'hFFFF_FFFE, 34};
        vecs[3] = '{3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4,  32'hFFFF_FFFF, 34};
        vecs[4] = '{3'b100, 32'hFFFF_FFF9, 32'h0000_0002, 5'd6,  32'hFFFF_FFFD, 34};
        vecs[5] = '{3'b110, 32'hFFFF_FFF9, 32'h0000_0002, 5'd7,  32'hFFFF_FFFF, 34};
        vecs[6] = '{3'b101, 32'h0000_1234, 32'h0000_0000, 5'd8,  32'hFFFF_FFFF, 1};
        vecs[7] = '{3'b111, 32'h0000_1234, 32'h0000_0000, 5'd10, 32'h0000_1234, 1};
        vecs[8] = '{3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 32'h8000_0000, 1};
        corners = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'h2};

        rst = 1'b1; start = 1'b0; flush = 1'b0; funct3 = '0;
        rs1_val = '0; rs2_val = '0; rd_in = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset busy", {31'b0, busy}, 32'h0);
        check("reset done", {31'b0, done}, 32'h0);
        check("reset result", result, 32'h0);
        check("reset rd_out", {27'b0, rd_out}, 32'h0);
        rst = 1'b0;

        for (int i = 0; i < 9; i++) begin
            run_op(vecs[i].f3, vecs[i].a, vecs[i].b, vecs[i].rd, 40, 1'b0, res, rdo, lat, ndone, nbusy);
            check($sformatf("vec%0d result", i), res, vecs[i].exp_res);
            check($sformatf("vec%0d rd_out", i), {27'b0, rdo}, {27'b0, vecs[i].rd});
            check($sformatf("vec%0d done cycle", i), lat, vecs[i].exp_lat);
            check($sformatf("vec%0d done count", i), ndone, 1);
            check($sformatf("vec%0d busy cycles", i), nbusy, (vecs[i].exp_lat == 34) ? 33 : 0);
            check($sformatf("vec%0d result held", i), result, vecs[i].exp_res);
        end

        // Flush at N+10, stray start at N+5, fresh DIVU start at N+11.
        @(negedge clk);
        start = 1'b1; funct3 = 3'b000; rs1_val = 32'd5; rs2_val = 32'd6; rd_in = 5'd3;
        ndone = 0; lat = 0; res = '0; rdo = '0;
        for (int c = 1; c <= 47; c++) begin
            @(posedge clk); #1;
            if (done) begin
                ndone++; lat = c; res = result; rdo = rd_out;
            end
            case (c)
                1:  start = 1'b0;
                5:  begin start = 1'b1; rd_in = 5'd5; end
                6:  start = 1'b0;
                10: begin check("flush busy before", {31'b0, busy}, 32'h1); flush = 1'b1; end
                11: begin
                    check("flush busy after", {31'b0, busy}, 32'h0);
                    flush = 1'b0; start = 1'b1; funct3 = 3'b101;
                    rs1_val = 32'd100; rs2_val = 32'd7; rd_in = 5'd9;
                end
                12: start = 1'b0;
                default: ;
            endcase
        end
        check("flush done count", ndone, 1);
        check("flush new op done cycle", lat, 45);
        check("flush new op result", res, 32'd14);
        check("flush new op rd_out", {27'b0, rdo}, 32'd9);

        // Flush and start together in IDLE: flush wins.
        @(negedge clk);
        start = 1'b1; flush = 1'b1; funct3 = 3'b000; rs1_val = 32'd3; rs2_val = 32'd3; rd_in = 5'd12;
        ndone = 0; nbusy = 0;
        for (int c = 1; c <= 36; c++) begin
            @(posedge clk); #1;
            if (c == 1) begin start = 1'b0; flush = 1'b0; end
            if (done) ndone++;
            if (busy) nbusy++;
        end
        check("flush+start done count", ndone, 0);
        check("flush+start busy cycles", nbusy, 0);

        // Reset mid-operation aborts without done and clears the result.
        @(negedge clk);
        start = 1'b1; funct3 = 3'b011; rs1_val = 32'd9; rs2_val = 32'd9; rd_in = 5'd13;
        ndone = 0;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk); #1;
            if (done) ndone++;
            if (c == 1) start = 1'b0;
            if (c == 5) rst = 1'b1;
            if (c == 6) begin
                rst = 1'b0;
                check("rst mid-op busy", {31'b0, busy}, 32'h0);
                check("rst mid-op result", result, 32'h0);
            end
        end
        check("rst mid-op done count", ndone, 0);

        for (int n = 0; n < 2000; n++) begin
            f3 = 3'($urandom_range(7, 0));
            a  = ($urandom_range(3, 0) == 0) ? corners[$urandom_range(5, 0)] : $urandom;
            b  = ($urandom_range(3, 0) == 0) ? corners[$urandom_range(5, 0)] : $urandom;
            if ($urandom_range(99, 0) < 5) b = 32'h0;
            rd = 5'($urandom_range(31, 0));
            exp_lat = (f3[2] && (b == 0 || (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF))) ? 1 : 34;
            run_op(f3, a, b, rd, 40, 1'b1, res, rdo, lat, ndone, nbusy);
            nm = $sformatf("rand op=%0d a=%h b=%h", f3, a, b);
            check({nm, " result"}, res, ref_model(f3, a, b));
            check({nm, " rd_out"}, {27'b0, rdo}, {27'b0, rd});
            check({nm, " done cycle"}, lat, exp_lat);
        end

        if (errors == 0) $display("mul_div_unit_tb PASS");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
